multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle controller for a small MIPS-like datapath.
// One instruction walks IF -> ID -> (EX) -> (MEM) -> (WB) -> IF; the datapath
// strobes are decoded combinationally from the current state plus the
// opcode/func captured on the ID->EX edge.
module multicycle_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ins_Opcode,
  input  logic [5:0]  ins_func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        ext_sel,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        mem_we,
  output logic        mem_re,
  output logic        reg_we,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    I_ADD, I_SUBU, I_SLTU, I_ORI, I_LW, I_SW, I_BEQ, I_J
  } icls_t;

  typedef struct packed {
    logic  legal;
    icls_t cls;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = I_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  d.cls = I_ADD;
          FN_SUBU: d.cls = I_SUBU;
          FN_SLTU: d.cls = I_SLTU;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ORI:  d.cls = I_ORI;
      OP_LW:   d.cls = I_LW;
      OP_SW:   d.cls = I_SW;
      OP_BEQ:  d.cls = I_BEQ;
      OP_J:    d.cls = I_J;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  op_q, func_q;
  logic [15:0] retired_q;
  logic        retire;
  logic        ir_we_c, pc_we_c, mem_we_c, mem_re_c, reg_we_c;
  dec_t        id_dec, ex_dec;

  // ID looks at the live instruction fields; later states use the captured copy
  assign id_dec = decode(ins_Opcode, ins_func);
  assign ex_dec = decode(op_q, func_q);

  // State register, instruction capture on ID->EX, retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      op_q      <= '0;
      func_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_q + 16'(retire);
      if (state_q == S_ID && state_d == S_EX) begin
        op_q   <= ins_Opcode;
        func_q <= ins_func;
      end
    end
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 3'b000;
    alu_src    = 1'b0;
    ext_sel    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_we_c   = 1'b0;
    mem_re_c   = 1'b0;
    reg_we_c   = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (!id_dec.legal) begin
          if (HALT_ON_ILLEGAL) begin
            state_d = S_HALT;
          end else begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else if (id_dec.cls == I_J) begin
          pc_we_c = 1'b1;
          pc_src  = 2'b10;
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (ex_dec.cls)
          I_ADD, I_SUBU, I_SLTU: begin
            reg_dst = 1'b1;
            alu_op  = (ex_dec.cls == I_SUBU) ? 3'b001 :
                      (ex_dec.cls == I_SLTU) ? 3'b010 : 3'b000;
            state_d = S_WB;
          end
          I_ORI: begin
            alu_src = 1'b1;
            alu_op  = 3'b011;
            state_d = S_WB;
          end
          I_LW, I_SW: begin
            alu_src = 1'b1;
            ext_sel = 1'b1;
            state_d = S_MEM;
          end
          I_BEQ: begin
            alu_op  = 3'b001;
            ext_sel = 1'b1;
            pc_src  = 2'b01;
            pc_we_c = zero;
            retire  = 1'b1;
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        // strobe held for the whole wait; no timeout by design
        case (ex_dec.cls)
          I_LW: begin
            mem_re_c = 1'b1;
            if (mem_ready) state_d = S_WB;
          end
          I_SW: begin
            mem_we_c = 1'b1;
            if (mem_ready) begin
              retire  = 1'b1;
              state_d = S_IF;
            end
          end
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        reg_we_c   = 1'b1;
        mem_to_reg = (ex_dec.cls == I_LW);
        reg_dst    = ex_dec.cls inside {I_ADD, I_SUBU, I_SLTU};
        retire     = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Strobes are gated by reset so an abort drops them without waiting for a clock
  assign ir_we   = ir_we_c  & rst_n;
  assign pc_we   = pc_we_c  & rst_n;
  assign mem_we  = mem_we_c & rst_n;
  assign mem_re  = mem_re_c & rst_n;
  assign reg_we  = reg_we_c & rst_n;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded by a
// small reference model into its expected per-cycle output records and the DUT
// is compared against them every cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  ins_Opcode, ins_func;
  logic        zero, mem_ready;
  logic [2:0]  state;
  logic        ir_we, pc_we, alu_src, ext_sel, reg_dst, mem_to_reg;
  logic        mem_we, mem_re, reg_we, halted;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ret;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .ins_Opcode(ins_Opcode), .ins_func(ins_func),
    .zero(zero), .mem_ready(mem_ready), .state(state), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .ext_sel(ext_sel), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_we(mem_we), .mem_re(mem_re), .reg_we(reg_we), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pcw;
    logic [1:0] pcs;
    logic [2:0] aop;
    logic       asrc, ext, rdst, m2r, mwe, mre, rwe, hlt;
  } exp_t;

  typedef enum {C_ADD, C_SUBU, C_SLTU, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_ILL} cls_t;

  exp_t q[$];
  logic rdy[$];

  function automatic exp_t observed();
    exp_t o;
    o = {state, ir_we, pc_we, pc_src, alu_op, alu_src, ext_sel, reg_dst,
         mem_to_reg, mem_we, mem_re, reg_we, halted};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h20: return C_ADD;
               6'h23: return C_SUBU;
               6'h2B: return C_SLTU;
               default: return C_ILL;
             endcase
      6'h0D: return C_ORI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // Expand one instruction into its expected cycle records
  function automatic void build(input cls_t c, input logic z, input int w);
    exp_t e;
    q.delete();
    rdy.delete();
    e = '0; e.st = 3'd0; e.ir = 1; e.pcw = 1;
    q.push_back(e); rdy.push_back(1'($urandom));
    e = '0; e.st = 3'd1;
    if (c == C_J) begin e.pcw = 1; e.pcs = 2'b10; end
    q.push_back(e); rdy.push_back(1'($urandom));
    if (c == C_ILL) begin
      for (int k = 0; k < 3; k++) begin
        e = '0; e.st = 3'd7; e.hlt = 1;
        q.push_back(e); rdy.push_back(1'($urandom));
      end
    end else if (c != C_J) begin
      e = '0; e.st = 3'd2;
      case (c)
        C_ADD, C_SUBU, C_SLTU: begin
          e.rdst = 1;
          e.aop = (c == C_SUBU) ? 3'd1 : (c == C_SLTU) ? 3'd2 : 3'd0;
        end
        C_ORI: begin e.asrc = 1; e.aop = 3'd3; end
        C_LW, C_SW: begin e.asrc = 1; e.ext = 1; end
        default: begin e.aop = 3'd1; e.ext = 1; e.pcs = 2'b01; e.pcw = z; end
      endcase
      q.push_back(e); rdy.push_back(1'($urandom));
      if (c == C_LW || c == C_SW) begin
        for (int k = 0; k <= w; k++) begin
          e = '0; e.st = 3'd3;
          if (c == C_LW) e.mre = 1; else e.mwe = 1;
          q.push_back(e); rdy.push_back(k == w);
        end
      end
      if (c inside {C_ADD, C_SUBU, C_SLTU, C_ORI, C_LW}) begin
        e = '0; e.st = 3'd4; e.rwe = 1;
        e.m2r = (c == C_LW);
        e.rdst = (c inside {C_ADD, C_SUBU, C_SLTU});
        q.push_back(e); rdy.push_back(1'($urandom));
      end
    end
  endfunction

  // Run one instruction; entered and left at a falling edge with DUT in IF
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int w, input int abort_at, input bit preload, input string nm);
    cls_t c;
    c = classify(op, fn);
    build(c, z, w);
    for (int i = 0; i < q.size(); i++) begin
      if (i <= 1) begin ins_Opcode = op; ins_func = fn; end
      else begin ins_Opcode = 6'($urandom); ins_func = 6'($urandom); end
      zero = z;
      mem_ready = rdy[i];
      #1;
      chk($sformatf("%s_c%0d", nm, i), 32'(observed()), 32'(q[i]));
      if (i == 0) chk({nm, "_ret"}, 32'(retired), 32'(exp_ret));
      if (preload && i == 0) begin
        force dut.retired_q = 16'hFFFF;
        exp_ret = 16'hFFFF;
      end
      if (preload && i == 1) begin
        release dut.retired_q;
        chk({nm, "_preload"}, 32'(retired), 32'h0000FFFF);
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_abort_mwe"}, 32'(mem_we), 32'd0);
        chk({nm, "_abort_st"}, 32'(state), 32'd0);
        chk({nm, "_abort_ret"}, 32'(retired), 32'd0);
        chk({nm, "_abort_strb"}, 32'({ir_we, pc_we, mem_re, reg_we}), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_abort_hold"}, 32'(observed()), 32'd0);
        exp_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (c == C_ILL) begin
      chk({nm, "_halt_ret"}, 32'(retired), 32'(exp_ret));
      rst_n = 1'b0;
      #1;
      chk({nm, "_halt_rst"}, 32'({state, halted}), 32'd0);
      exp_ret = '0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      exp_ret = exp_ret + 16'd1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog state=%0d", state);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [3];
    logic [5:0] bad_ops [3];
    logic [5:0] bad_fns [3];
    int k;
    ops = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
    fns = '{6'h20, 6'h23, 6'h2B};
    bad_ops = '{6'h3F, 6'h01, 6'h08};
    bad_fns = '{6'h21, 6'h00, 6'h2A};

    rst_n = 1'b0; ins_Opcode = '0; ins_func = '0; zero = 0; mem_ready = 0;
    exp_ret = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", 32'(observed()), 32'd0);
    chk("reset_ret", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'h00, 6'h20, 0, 0, -1, 0, "add");
    run_instr(6'h23, 6'h00, 0, 3, -1, 0, "lw_w3");
    run_instr(6'h04, 6'h00, 1, 0, -1, 0, "beq_t");
    run_instr(6'h04, 6'h00, 0, 0, -1, 0, "beq_n");
    run_instr(6'h02, 6'h00, 0, 0, -1, 0, "j");
    run_instr(6'h0D, 6'h00, 0, 0, -1, 0, "ori");
    run_instr(6'h02, 6'h00, 0, 0, -1, 1, "j_wrap");
    run_instr(6'h00, 6'h23, 0, 0, -1, 0, "subu");
    run_instr(6'h2B, 6'h00, 0, 3, 4, 0, "sw_abort");
    run_instr(6'h2B, 6'h00, 0, 2, -1, 0, "sw_w2");
    run_instr(6'h3F, 6'h00, 0, 0, -1, 0, "illegal");

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 11);
      if (k < 8)
        run_instr(ops[k], (k < 3) ? fns[k] : 6'($urandom), 1'($urandom),
                  $urandom_range(0, 3), -1, 0, $sformatf("rnd%0d", n));
      else if (k < 10)
        run_instr(6'h00, bad_fns[$urandom_range(0, 2)], 0, 0, -1, 0, $sformatf("rndbf%0d", n));
      else if (k == 10)
        run_instr(bad_ops[$urandom_range(0, 2)], 6'($urandom), 0, 0, -1, 0, $sformatf("rndbo%0d", n));
      else
        run_instr(6'h23, 6'($urandom), 1'($urandom), $urandom_range(0, 5), -1, 0, $sformatf("rndlw%0d", n));
    end

    #1;
    chk("final_st", 32'(state), 32'd0);
    chk("final_ret", 32'(retired), 32'(exp_ret));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
